// File: rtl/vit_pkg.sv
// Shared types and constants for the radix-4 Viterbi decoder control path.
// Holds the controller state encoding and trellis geometry.
package vit_pkg;

    localparam int VIT_STATE_W    = 8;
    localparam int RADIX          = 4;
    localparam int MAX_STATE_NUM  = 256;
    localparam int MAX_FRAME_DEF  = 1024;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLR     = 3'd1,
        ST_ACS     = 3'd2,
        ST_TB_LOAD = 3'd3,
        ST_TB      = 3'd4,
        ST_DONE    = 3'd5
    } vit_state_t;

endpackage

// File: rtl/vit_frame_cnt.sv
// Loadable frame counter with terminal-count compare; counts up or down per UP.
// Latency: load/step visible the cycle after the edge. No backpressure; caller gates en.
module vit_frame_cnt #(
    parameter int ADDR_W = 10,
    parameter bit UP     = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W:0]   load_val,
    input  logic              en,
    input  logic [ADDR_W:0]   term,
    output logic [ADDR_W-1:0] addr,
    output logic              tc
);

    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= UP ? (cnt + ONE) : (cnt - ONE);
        end
    end

    assign addr = cnt[ADDR_W-1:0];
    assign tc   = (cnt == term);

endmodule

// File: rtl/viterbi_ctrl.sv
// Frame sequencer: ACS/survivor-write phase, then full-frame traceback. Optional VIT_ZERO_TERM_EN.
// Latency: 2N+4 cycles start-to-done unstalled; symbol backpressure via o_sym_ready (ACS state only).
module viterbi_ctrl
    import vit_pkg::*;
#(
    parameter int MAX_FRAME = MAX_FRAME_DEF,
    parameter int ADDR_W    = $clog2(MAX_FRAME),
    parameter int STATE_W   = VIT_STATE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [ADDR_W:0]    i_frame_len,
    input  logic               i_sym_valid,
    output logic               o_sym_ready,
    output logic               o_acs_clr,
    output logic               o_en_acs,
    output logic               o_sm_wr_en,
    output logic [ADDR_W-1:0]  o_sm_wr_addr,
    input  logic [STATE_W-1:0] i_sel_node,
    output logic               o_en_tb,
    output logic [ADDR_W-1:0]  o_tb_rd_addr,
    output logic [STATE_W-1:0] o_tb_start_st,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);

    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(MAX_FRAME);
    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

    vit_state_t state, next_state;

    logic [ADDR_W:0]    len_q;
    logic               len_ok;
    logic               sym_tc;
    logic               tb_tc;
    logic               sym_ready_d;
    logic               acs_clr_d;
    logic               en_tb_d;
    logic               busy_d;
    logic               done_d;
    logic               err_d;
    logic [STATE_W-1:0] start_st_d;

    assign len_ok = (i_frame_len != '0) && (i_frame_len <= MAX_LEN);

    // Accept is purely combinational so the ACS sees the symbol in the same cycle.
    assign o_en_acs   = o_sym_ready && i_sym_valid;
    assign o_sm_wr_en = o_en_acs;

    vit_frame_cnt #(.ADDR_W(ADDR_W), .UP(1'b1)) u_sym_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (state == ST_CLR),
        .load_val ('0),
        .en       (o_en_acs),
        .term     (len_q - ONE),
        .addr     (o_sm_wr_addr),
        .tc       (sym_tc)
    );

    // Holds at zero after the final step so the read address rests at 0 in IDLE.
    vit_frame_cnt #(.ADDR_W(ADDR_W), .UP(1'b0)) u_tb_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (state == ST_TB_LOAD),
        .load_val (len_q - ONE),
        .en       ((state == ST_TB) && !tb_tc),
        .term     ('0),
        .addr     (o_tb_rd_addr),
        .tc       (tb_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            len_q <= '0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && i_start && len_ok) begin
                len_q <= i_frame_len;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (i_start && len_ok) next_state = ST_CLR;
            ST_CLR:     next_state = ST_ACS;
            ST_ACS:     if (o_en_acs && sym_tc) next_state = ST_TB_LOAD;
            ST_TB_LOAD: next_state = ST_TB;
            ST_TB:      if (tb_tc) next_state = ST_DONE;
            ST_DONE:    next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // Outputs are decoded from next_state and registered, so they align with the state.
    always_comb begin
        sym_ready_d = (next_state == ST_ACS);
        acs_clr_d   = (next_state == ST_CLR);
        en_tb_d     = (next_state == ST_TB);
        busy_d      = (next_state != ST_IDLE);
        done_d      = (next_state == ST_DONE);
        err_d       = (state == ST_IDLE) && i_start && !len_ok;
        start_st_d  = o_tb_start_st;
        if (state == ST_TB_LOAD) begin
`ifdef VIT_ZERO_TERM_EN
            start_st_d = '0;
`else
            start_st_d = i_sel_node;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_sym_ready   <= 1'b0;
            o_acs_clr     <= 1'b0;
            o_en_tb       <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_err         <= 1'b0;
            o_tb_start_st <= '0;
        end else begin
            o_sym_ready   <= sym_ready_d;
            o_acs_clr     <= acs_clr_d;
            o_en_tb       <= en_tb_d;
            o_busy        <= busy_d;
            o_done        <= done_d;
            o_err         <= err_d;
            o_tb_start_st <= start_st_d;
        end
    end

endmodule

// File: tb/tb_viterbi_ctrl.sv
// Bench for viterbi_ctrl: frame scenarios with a write/traceback address scoreboard.
// Span = cycles from the i_start cycle through the o_done cycle inclusive (2N+4 unstalled).
module tb_viterbi_ctrl;

    localparam int MAX_FRAME = 1024;
    localparam int ADDR_W    = 10;
    localparam int STATE_W   = 8;

    logic               clk;
    logic               rst;
    logic               i_start;
    logic [ADDR_W:0]    i_frame_len;
    logic               i_sym_valid;
    logic               o_sym_ready;
    logic               o_acs_clr;
    logic               o_en_acs;
    logic               o_sm_wr_en;
    logic [ADDR_W-1:0]  o_sm_wr_addr;
    logic [STATE_W-1:0] i_sel_node;
    logic               o_en_tb;
    logic [ADDR_W-1:0]  o_tb_rd_addr;
    logic [STATE_W-1:0] o_tb_start_st;
    logic               o_busy;
    logic               o_done;
    logic               o_err;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    int wr_q[$];
    int tb_q[$];

    viterbi_ctrl #(.MAX_FRAME(MAX_FRAME), .ADDR_W(ADDR_W), .STATE_W(STATE_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_frame_len   (i_frame_len),
        .i_sym_valid   (i_sym_valid),
        .o_sym_ready   (o_sym_ready),
        .o_acs_clr     (o_acs_clr),
        .o_en_acs      (o_en_acs),
        .o_sm_wr_en    (o_sm_wr_en),
        .o_sm_wr_addr  (o_sm_wr_addr),
        .i_sel_node    (i_sel_node),
        .o_en_tb       (o_en_tb),
        .o_tb_rd_addr  (o_tb_rd_addr),
        .o_tb_start_st (o_tb_start_st),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_err         (o_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] exp_start(input logic [7:0] sel);
`ifdef VIT_ZERO_TERM_EN
        return 8'h00;
`else
        return sel;
`endif
    endfunction

    function automatic logic [40:0] all_outs();
        return {o_sym_ready, o_acs_clr, o_en_acs, o_sm_wr_en, o_sm_wr_addr, o_en_tb,
                o_tb_rd_addr, o_tb_start_st, o_busy, o_done, o_err};
    endfunction

    // Drives one frame; stall_mask bit k drops i_sym_valid on loop iteration k (iteration 0 = CLR cycle).
    task automatic run_frame(input int len, input logic [7:0] sel, input logic [63:0] stall_mask,
                             input int inject_it, output int span, output int nwr,
                             output int ntb, output int nerrp);
        int  s;
        int  exp_a;
        bit  got;
        wr_q.delete();
        tb_q.delete();
        for (int i = 0; i < len; i++) begin
            wr_q.push_back(i);
            tb_q.push_back(len - 1 - i);
        end
        span = -1; nwr = 0; ntb = 0; nerrp = 0; got = 0;
        @(posedge clk); #1;
        i_start = 1'b1; i_frame_len = (ADDR_W+1)'(len); i_sel_node = sel; i_sym_valid = 1'b0;
        s = cyc;
        for (int it = 0; it < 3 * len + 40 && !got; it++) begin
            @(posedge clk); #1;
            i_start     = (it == inject_it);
            i_frame_len = (it == inject_it) ? '0 : (ADDR_W+1)'(len);
            i_sym_valid = (it < 64) ? !stall_mask[it] : 1'b1;
            @(negedge clk);
            if (it == 0) begin
                nchk++;
                if ({o_acs_clr, o_busy} !== 2'b11) begin
                    nerr++;
                    $display("FAIL clr_cycle: acs_clr/busy=%b expected 11", {o_acs_clr, o_busy});
                end
            end
            if (o_err) nerrp++;
            if (o_en_acs) begin
                nwr++;
                nchk++;
                exp_a = (wr_q.size() > 0) ? wr_q.pop_front() : -1;
                if (o_sm_wr_en !== 1'b1 || int'(o_sm_wr_addr) != exp_a) begin
                    nerr++;
                    $display("FAIL wr_addr: wr_en=%b addr=%0d expected 1/%0d", o_sm_wr_en, o_sm_wr_addr, exp_a);
                end
            end
            if (o_en_tb) begin
                ntb++;
                nchk++;
                exp_a = (tb_q.size() > 0) ? tb_q.pop_front() : -1;
                if (int'(o_tb_rd_addr) != exp_a || o_tb_start_st !== exp_start(sel)) begin
                    nerr++;
                    $display("FAIL tb_step: addr=%0d st=%h expected %0d/%h",
                             o_tb_rd_addr, o_tb_start_st, exp_a, exp_start(sel));
                end
            end
            if (o_done) begin
                span = cyc - s + 1;
                got  = 1;
            end
        end
        i_start = 1'b0; i_sym_valid = 1'b0;
        if (!got) begin
            nerr++;
            $display("FAIL frame_timeout: len=%0d no o_done within budget", len);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #23;
        nchk++;
        if (all_outs() !== '0) begin
            nerr++;
            $display("FAIL reset_outputs: got %h expected 0", all_outs());
        end
        rst = 1'b1;
    endtask

    task automatic test_reset_mid_acs();
        int acc = 0;
        int span, nwr, ntb, ne;
        @(posedge clk); #1;
        i_start = 1'b1; i_frame_len = 11'd8; i_sel_node = 8'h11; i_sym_valid = 1'b1;
        for (int k = 0; k < 20 && acc < 3; k++) begin
            @(posedge clk); #1;
            i_start = 1'b0;
            @(negedge clk);
            if (o_en_acs) acc++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        nchk++;
        if (all_outs() !== '0) begin
            nerr++;
            $display("FAIL reset_mid_acs: got %h expected 0", all_outs());
        end
        i_sym_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_frame(4, 8'h22, 64'd0, -1, span, nwr, ntb, ne);
        nchk++;
        if (span != 12 || nwr != 4 || ntb != 4) begin
            nerr++;
            $display("FAIL after_reset_frame: span=%0d wr=%0d tb=%0d expected 12/4/4", span, nwr, ntb);
        end
    endtask

    task automatic test_unstalled();
        int span, nwr, ntb, ne;
        run_frame(5, 8'hA3, 64'd0, -1, span, nwr, ntb, ne);
        nchk++;
        if (span != 14 || nwr != 5 || ntb != 5 || ne != 0) begin
            nerr++;
            $display("FAIL unstalled: span=%0d wr=%0d tb=%0d err=%0d expected 14/5/5/0", span, nwr, ntb, ne);
        end
    endtask

    task automatic test_stall();
        int span, nwr, ntb, ne;
        run_frame(4, 8'h37, 64'h34, -1, span, nwr, ntb, ne);
        nchk++;
        if (span != 15 || nwr != 4 || ntb != 4) begin
            nerr++;
            $display("FAIL stalled: span=%0d wr=%0d tb=%0d expected 15/4/4", span, nwr, ntb);
        end
    endtask

    task automatic test_reject();
        int errs, busys;
        logic [ADDR_W:0] bad_len [2];
        bad_len[0] = '0;
        bad_len[1] = (ADDR_W+1)'(MAX_FRAME + 1);
        for (int b = 0; b < 2; b++) begin
            errs = 0; busys = 0;
            @(posedge clk); #1;
            i_start = 1'b1; i_frame_len = bad_len[b];
            for (int k = 0; k < 4; k++) begin
                @(posedge clk); #1;
                i_start = 1'b0;
                @(negedge clk);
                if (o_err) errs++;
                if (o_busy) busys++;
            end
            nchk++;
            if (errs != 1 || busys != 0) begin
                nerr++;
                $display("FAIL reject_len%0d: err_pulses=%0d busy_cycles=%0d expected 1/0", bad_len[b], errs, busys);
            end
        end
    endtask

    task automatic test_ignore_start_in_tb();
        int span, nwr, ntb, ne;
        // Iteration 8 of a len=5 frame lands in TB; a zero-length start there must not flag.
        run_frame(5, 8'h4E, 64'd0, 8, span, nwr, ntb, ne);
        nchk++;
        if (span != 14 || ne != 0 || ntb != 5) begin
            nerr++;
            $display("FAIL ignore_start_tb: span=%0d err=%0d tb=%0d expected 14/0/5", span, ne, ntb);
        end
        @(negedge clk);
        nchk++;
        if (o_busy !== 1'b0 || o_err !== 1'b0) begin
            nerr++;
            $display("FAIL idle_after_frame: busy=%b err=%b expected 0/0", o_busy, o_err);
        end
    endtask

    task automatic test_boundaries();
        int span, nwr, ntb, ne;
        run_frame(1, 8'h01, 64'd0, -1, span, nwr, ntb, ne);
        nchk++;
        if (span != 6 || nwr != 1 || ntb != 1) begin
            nerr++;
            $display("FAIL len1: span=%0d wr=%0d tb=%0d expected 6/1/1", span, nwr, ntb);
        end
        run_frame(MAX_FRAME, 8'hF0, 64'd0, -1, span, nwr, ntb, ne);
        nchk++;
        if (span != 2 * MAX_FRAME + 4 || nwr != MAX_FRAME || ntb != MAX_FRAME) begin
            nerr++;
            $display("FAIL len_max: span=%0d wr=%0d tb=%0d expected %0d/%0d/%0d",
                     span, nwr, ntb, 2 * MAX_FRAME + 4, MAX_FRAME, MAX_FRAME);
        end
    endtask

    task automatic test_start_state();
        int span, nwr, ntb, ne;
        run_frame(3, 8'h5C, 64'd0, -1, span, nwr, ntb, ne);
        @(negedge clk);
        nchk++;
        if (o_tb_start_st !== exp_start(8'h5C)) begin
            nerr++;
            $display("FAIL start_state: got %h expected %h", o_tb_start_st, exp_start(8'h5C));
        end
    endtask

    initial begin
        rst = 1'b0; i_start = 1'b0; i_frame_len = '0; i_sym_valid = 1'b0; i_sel_node = '0;
        test_reset();
        test_reset_mid_acs();
        test_unstalled();
        test_stall();
        test_reject();
        test_ignore_start_in_tb();
        test_boundaries();
        test_start_state();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
